// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam logic [31:0] INST_NOP = 32'h00000013;
  localparam logic [63:0] PC_STEP  = 64'd4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    RUN      = 1'b0,
    MISALIGN = 1'b1
  } fetch_state_e;

  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy count
// Push and pop may coincide at any occupancy; flush overrides both.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, imem request/response tracking and ID-side buffer
// Optional misaligned-redirect reporting is enabled with FETCH_MISALIGN_CHECK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken_in,
  input  logic [63:0] branch_target_in,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        if_misaligned
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = ((OW > CW) ? OW : CW) + 1;
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] CRED_MAX = SW'(FIFO_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  fetch_state_e  state_q, state_d;

  logic          req_fire;
  logic          resp_keep;
  logic          tgt_misaligned;
  logic [63:0]   tgt_aligned;
  logic          fifo_valid;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_push_data;

  assign tgt_aligned = align_pc(branch_target_in);
`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt_misaligned = (branch_target_in[1:0] != 2'b00);
`else
  assign tgt_misaligned = 1'b0;
`endif

  // Credit covers both in-flight requests and buffered entries, so every response has a slot.
  always_comb begin
    imem_req_valid = reset && (state_q == RUN) && !branch_taken_in
                     && (outstanding_q < OUT_MAX)
                     && ((SW'(outstanding_q) + SW'(fifo_count)) < CRED_MAX);
    imem_req_addr  = pc_q;
  end

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_keep = imem_resp_valid && !branch_taken_in && (drop_cnt_q == '0);

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    state_d       = state_q;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_resp_valid);
    if (branch_taken_in) begin
      pc_d       = tgt_aligned;
      resp_pc_d  = tgt_aligned;
      // Everything still in flight after this cycle belongs to the wrong path.
      drop_cnt_d = outstanding_d;
      state_d    = tgt_misaligned ? MISALIGN : RUN;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_STEP;
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      state_q       <= RUN;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
    end
  end

  assign fifo_push_data = '{pc: resp_pc_q, inst: imem_resp_data};
  assign fifo_valid     = !fifo_empty && !branch_taken_in && (state_q == RUN);
  assign fifo_pop       = fifo_valid && if_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (branch_taken_in),
    .push      (resp_keep),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  logic [63:0] mis_pc_q, mis_pc_d;
  logic        mis_pending_q, mis_pending_d;

  always_comb begin
    mis_pc_d      = mis_pc_q;
    mis_pending_d = mis_pending_q;
    if (branch_taken_in) begin
      mis_pc_d      = branch_target_in;
      mis_pending_d = tgt_misaligned;
    end else if ((state_q == MISALIGN) && mis_pending_q && if_ready) begin
      mis_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_pc_q      <= '0;
      mis_pending_q <= 1'b0;
    end else begin
      mis_pc_q      <= mis_pc_d;
      mis_pending_q <= mis_pending_d;
    end
  end

  always_comb begin
    if_valid      = fifo_valid;
    if_pc         = fifo_head.pc;
    if_inst       = fifo_head.inst;
    if_misaligned = 1'b0;
    if (state_q == MISALIGN) begin
      if_valid      = mis_pending_q && !branch_taken_in;
      if_pc         = mis_pc_q;
      if_inst       = INST_NOP;
      if_misaligned = mis_pending_q && !branch_taken_in;
    end
  end
`else
  always_comb begin
    if_valid = fifo_valid;
    if_pc    = fifo_head.pc;
    if_inst  = fifo_head.inst;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized fetch-stage bench against a queue-based reference model
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk;
  logic        reset;
  logic        branch_taken_in;
  logic [63:0] branch_target_in;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        if_misaligned;
`endif

  fetch_stage #(
    .RESET_PC        (RESET_PC),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc            (if_pc),
    .if_inst          (if_inst)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .if_misaligned    (if_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int rdy_pct, ifr_pct, br_pct, lat_min, lat_max;
  logic        force_br;
  logic [63:0] force_tgt;

  // Reference state: pending memory requests, kept-entry queue, wrong-path drop budget.
  logic [63:0]  m_pc;
  int           m_drop;
  pend_t        m_pend[$];
  fetch_entry_t m_q[$];
  logic         m_mis;
  logic         m_mis_pend;
  logic [63:0]  m_mis_pc;

  logic [63:0] acc_log[$];
  int          acc_cyc[$];
  logic [63:0] pop_log[$];
  int          first_iv_cyc;
  logic        br_rv, br_iv;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ (a[31:0] << 7) ^ a[63:32] ^ 32'hA5C3_0F11;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pc       = RESET_PC;
    m_drop     = 0;
    m_mis      = 1'b0;
    m_mis_pend = 1'b0;
    m_mis_pc   = '0;
    m_pend.delete();
    m_q.delete();
    acc_log.delete();
    acc_cyc.delete();
    pop_log.delete();
    first_iv_cyc = -1;
    cyc = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset            = 1'b0;
    branch_taken_in  = 1'b0;
    branch_target_in = '0;
    imem_req_ready   = 1'b0;
    imem_resp_valid  = 1'b0;
    imem_resp_data   = '0;
    if_ready         = 1'b0;
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", if_pc, 64'd0);
    check("rst_if_inst", 64'(if_inst), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic step();
    logic        br, resp, rv_e, iv_e;
    logic [63:0] tgt, pc_e;
    logic [31:0] inst_e;
    pend_t       p;
    @(negedge clk);
    br  = force_br ? 1'b1 : ($urandom_range(99) < br_pct);
    tgt = force_br ? force_tgt : {32'h0, $urandom_range(32'hFFFF, 0)};
    if (!force_br && $urandom_range(3) == 0)
      tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
    force_br = 1'b0;
    resp = (m_pend.size() > 0) && (m_pend[0].due <= cyc);
    branch_taken_in  = br;
    branch_target_in = tgt;
    imem_req_ready   = ($urandom_range(99) < rdy_pct);
    imem_resp_valid  = resp;
    imem_resp_data   = resp ? mem_word(m_pend[0].addr) : $urandom;
    if_ready         = ($urandom_range(99) < ifr_pct);
    #1;
    rv_e = !br && !m_mis && (m_pend.size() < MAXO) && (m_pend.size() + m_q.size() < DEPTH);
    if (m_mis) begin
      iv_e   = m_mis_pend && !br;
      pc_e   = m_mis_pc;
      inst_e = INST_NOP;
    end else begin
      iv_e   = (m_q.size() > 0) && !br;
      pc_e   = (m_q.size() > 0) ? m_q[0].pc : '0;
      inst_e = (m_q.size() > 0) ? m_q[0].inst : '0;
    end
    check("req_valid", 64'(imem_req_valid), 64'(rv_e));
    check("req_addr", imem_req_addr, m_pc);
    check("if_valid", 64'(if_valid), 64'(iv_e));
    if (iv_e) begin
      check("if_pc", if_pc, pc_e);
      check("if_inst", 64'(if_inst), 64'(inst_e));
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    check("if_misaligned", 64'(if_misaligned), 64'(iv_e && m_mis));
`endif
    if (imem_req_valid && imem_req_ready) begin
      acc_log.push_back(imem_req_addr);
      acc_cyc.push_back(cyc);
    end
    if (if_valid && if_ready) pop_log.push_back(if_pc);
    if (if_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
    if (br) begin
      br_rv = imem_req_valid;
      br_iv = if_valid;
    end

    if (iv_e && if_ready) begin
      if (m_mis) m_mis_pend = 1'b0;
      else void'(m_q.pop_front());
    end
    if (resp) begin
      p = m_pend.pop_front();
      if (!br) begin
        if (m_drop > 0) m_drop--;
        else m_q.push_back('{pc: p.addr, inst: mem_word(p.addr)});
      end
    end
    if (br) begin
      m_q.delete();
      m_drop = m_pend.size();
      m_pc   = {tgt[63:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
      m_mis = (tgt[1:0] != 2'b00);
`else
      m_mis = 1'b0;
`endif
      m_mis_pend = m_mis;
      m_mis_pc   = tgt;
    end else if (rv_e && imem_req_ready) begin
      m_pend.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_min, lat_max)});
      m_pc = m_pc + 64'd4;
    end
    cyc++;
  endtask

  task automatic knobs(input int rdy, input int ifr, input int brp, input int lmin, input int lmax);
    rdy_pct = rdy;
    ifr_pct = ifr;
    br_pct  = brp;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  initial begin
    int n;
    reset            = 1'b0;
    branch_taken_in  = 1'b0;
    branch_target_in = '0;
    imem_req_ready   = 1'b0;
    imem_resp_valid  = 1'b0;
    imem_resp_data   = '0;
    if_ready         = 1'b0;
    force_br         = 1'b0;
    force_tgt        = '0;
    br_rv            = 1'b1;
    br_iv            = 1'b1;
    model_clear();
    knobs(100, 100, 0, 1, 1);
    #2;
    check("init_req_valid", 64'(imem_req_valid), 64'd0);
    check("init_req_addr", imem_req_addr, RESET_PC);

    // Sequential fetch with a single-cycle memory
    do_reset();
    repeat (10) step();
    check("t1_nacc", 64'(acc_log.size() >= 3), 64'd1);
    if (acc_log.size() >= 3) begin
      check("t1_addr0", acc_log[0], 64'h0);
      check("t1_addr1", acc_log[1], 64'h4);
      check("t1_addr2", acc_log[2], 64'h8);
      check("t1_latency", 64'(first_iv_cyc - acc_cyc[0]), 64'd2);
    end
    check("t1_npop", 64'(pop_log.size() >= 1), 64'd1);
    if (pop_log.size() >= 1) check("t1_pop0", pop_log[0], 64'h0);

    // ID stalls: requests stop at the buffer depth
    do_reset();
    knobs(100, 0, 0, 1, 1);
    repeat (20) step();
    check("t2_acc_stall", 64'(acc_log.size()), 64'd4);
    knobs(100, 100, 0, 1, 1);
    repeat (10) step();
    check("t2_npop", 64'(pop_log.size() >= 4), 64'd1);
    if (pop_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t2_pop_seq", pop_log[i], 64'(4 * i));
    end

    // Redirect with two requests in flight on a 3-cycle memory
    do_reset();
    knobs(100, 100, 0, 3, 3);
    repeat (2) step();
    force_br  = 1'b1;
    force_tgt = 64'h100;
    step();
    check("t3_br_req_valid", 64'(br_rv), 64'd0);
    repeat (15) step();
    check("t3_npop", 64'(pop_log.size() >= 1), 64'd1);
    if (pop_log.size() >= 1) check("t3_first_pc", pop_log[0], 64'h100);
    if (acc_log.size() >= 3) check("t3_acc_tgt", acc_log[2], 64'h100);

    // Redirect coinciding with a response and a ready memory
    do_reset();
    knobs(100, 100, 0, 2, 2);
    repeat (3) step();
    force_br  = 1'b1;
    force_tgt = 64'h200;
    step();
    check("t4_br_req_valid", 64'(br_rv), 64'd0);
    check("t4_br_if_valid", 64'(br_iv), 64'd0);
    repeat (12) step();
    if (pop_log.size() >= 1) check("t4_first_pc", pop_log[0], 64'h200);
    else check("t4_npop", 64'(pop_log.size()), 64'd1);
    if (acc_log.size() >= 3) check("t4_acc_tgt", acc_log[2], 64'h200);

`ifdef FETCH_MISALIGN_CHECK_EN
    do_reset();
    knobs(100, 0, 0, 1, 1);
    repeat (3) step();
    force_br  = 1'b1;
    force_tgt = 64'h102;
    step();
    n = acc_log.size();
    repeat (8) step();
    check("t6_no_req", 64'(acc_log.size()), 64'(n));
    knobs(100, 100, 0, 1, 1);
    repeat (3) step();
    if (pop_log.size() >= 1) check("t6_pop_pc", pop_log[pop_log.size() - 1], 64'h102);
    force_br  = 1'b1;
    force_tgt = 64'h200;
    step();
    repeat (5) step();
    if (acc_log.size() > n) check("t6_resume", acc_log[n], 64'h200);
    else check("t6_resume_n", 64'(acc_log.size()), 64'(n + 1));
`endif

    // Randomized traffic with a mid-run asynchronous reset
    do_reset();
    for (int seg = 0; seg < 30; seg++) begin
      knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(8, 0), 1,
            $urandom_range(4, 1));
      if (seg == 15) do_reset();
      repeat (100) step();
    end
    n = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
